// File: rtl/waveform_analyzer.sv
// -----------------------------------------------------------------------------
// waveform_analyzer
//
// Receive-side period/amplitude analyzer for a stream of signed samples (DAC
// generator loopback or an ADC stream). A Schmitt trigger with symmetric
// thresholds +/-HYST finds rising zero crossings. Between two consecutive
// rising crossings the block counts accepted samples and tracks the minimum
// and maximum sample. One result record is emitted per full period through a
// one-deep AXI-Stream holding buffer.
//
// Ports:
//   clk            clock
//   aresetn        synchronous reset, active low
//   enable         analysis enable (level); low returns the FSM to IDLE
//   clr            one-cycle pulse clearing the sticky flags
//   s_axis_tvalid  sample valid
//   s_axis_tdata   sample; the low DAC_WIDTH bits are a signed value
//   s_axis_tready  sample ready (high in every cycle after reset)
//   m_axis_tvalid  result valid
//   m_axis_tdata   result: [63:48] max, [47:32] min (sign-extended to 16 bits),
//                  [31:0] period in samples (zero-extended)
//   m_axis_tready  result ready
//   overrun        sticky: a result was dropped because the buffer was full
//   timeout        sticky: the period counter saturated before a crossing
//
// Parameters:
//   AXIS_TDATA_WIDTH  input bus width
//   DAC_WIDTH         signed bits of a sample (at most 16)
//   CNT_WIDTH         period counter width (at most 32)
//   HYST              positive hysteresis threshold below 2^(DAC_WIDTH-1)
// -----------------------------------------------------------------------------
module waveform_analyzer #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = 14,
  parameter int CNT_WIDTH        = 32,
  parameter int HYST             = 64
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic                        clr,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                        s_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [63:0]                 m_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        overrun,
  output logic                        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic signed [DAC_WIDTH-1:0] HYST_HI  = DAC_WIDTH'(HYST);
  localparam logic signed [DAC_WIDTH-1:0] HYST_LO  = -HYST_HI;
  localparam logic [CNT_WIDTH-1:0]        CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  // One below all-ones: the increment from here would saturate the counter.
  localparam logic [CNT_WIDTH-1:0]        CNT_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DAC_WIDTH-1:0]        VAL_ZERO = {DAC_WIDTH{1'b0}};

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic signed [DAC_WIDTH-1:0] smin(
    input logic signed [DAC_WIDTH-1:0] a,
    input logic signed [DAC_WIDTH-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [DAC_WIDTH-1:0] smax(
    input logic signed [DAC_WIDTH-1:0] a,
    input logic signed [DAC_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] sext16(input logic signed [DAC_WIDTH-1:0] v);
    logic signed [15:0] w;
    w = 16'(v);
    return w;
  endfunction

  function automatic logic [31:0] zext32(input logic [CNT_WIDTH-1:0] c);
    return 32'(c);
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t                       state_r;
  state_t                       state_nxt_s;
  logic                         schmitt_r;
  logic                         schmitt_nxt_s;
  logic                         schmitt_upd_s;
  logic [CNT_WIDTH-1:0]         cnt_r;
  logic [CNT_WIDTH-1:0]         cnt_nxt_s;
  logic signed [DAC_WIDTH-1:0]  min_r;
  logic signed [DAC_WIDTH-1:0]  min_nxt_s;
  logic signed [DAC_WIDTH-1:0]  max_r;
  logic signed [DAC_WIDTH-1:0]  max_nxt_s;
  logic signed [DAC_WIDTH-1:0]  sample_s;
  logic                         accept_s;
  logic                         rise_s;
  logic                         fall_s;
  logic                         offer_s;
  logic                         tmo_set_s;
  logic                         buf_free_s;
  logic [63:0]                  rec_s;
  logic                         unused_tdata_s;

  assign accept_s = s_axis_tvalid & s_axis_tready;
  assign sample_s = s_axis_tdata[DAC_WIDTH-1:0];
  // Bits above DAC_WIDTH carry no information for the analysis.
  assign unused_tdata_s = ^s_axis_tdata;

  // Threshold crossings are qualified by the accept and by the current
  // Schmitt state, so a rising event happens exactly once per LOW->HIGH.
  assign rise_s = accept_s & ~schmitt_r & (sample_s >= HYST_HI);
  assign fall_s = accept_s &  schmitt_r & (sample_s <= HYST_LO);

  // The record always describes the period that ended before the event
  // sample, so it is built from the registered (pre-update) values.
  assign rec_s = {sext16(max_r), sext16(min_r), zext32(cnt_r)};

  // A held record is free to be replaced when it is consumed in this cycle.
  assign buf_free_s = ~m_axis_tvalid | m_axis_tready;

  // Schmitt trigger update for the current sample
  always_comb begin
    schmitt_upd_s = schmitt_r;
    if (rise_s) begin
      schmitt_upd_s = 1'b1;
    end else if (fall_s) begin
      schmitt_upd_s = 1'b0;
    end else begin
      schmitt_upd_s = schmitt_r;
    end
  end

  // Next-state, measurement update and record/flag requests
  always_comb begin
    state_nxt_s   = state_r;
    schmitt_nxt_s = schmitt_r;
    cnt_nxt_s     = cnt_r;
    min_nxt_s     = min_r;
    max_nxt_s     = max_r;
    offer_s       = 1'b0;
    tmo_set_s     = 1'b0;
    // Dropping enable wins over everything, including a coincident event:
    // the partial measurement is simply abandoned.
    if (!enable) begin
      state_nxt_s   = ST_IDLE;
      schmitt_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s   = ST_SEEK;
          schmitt_nxt_s = 1'b0;
        end
        ST_SEEK: begin
          schmitt_nxt_s = schmitt_upd_s;
          if (rise_s) begin
            state_nxt_s = ST_MEASURE;
            cnt_nxt_s   = CNT_ONE;
            min_nxt_s   = sample_s;
            max_nxt_s   = sample_s;
          end else begin
            state_nxt_s = ST_SEEK;
          end
        end
        ST_MEASURE: begin
          schmitt_nxt_s = schmitt_upd_s;
          if (rise_s) begin
            // Period closed: publish it and start the next one with the
            // event sample as its first sample.
            offer_s     = 1'b1;
            state_nxt_s = ST_MEASURE;
            cnt_nxt_s   = CNT_ONE;
            min_nxt_s   = sample_s;
            max_nxt_s   = sample_s;
          end else if (accept_s) begin
            if (cnt_r == CNT_LAST) begin
              // Counter would saturate: give up on this period, no record.
              tmo_set_s   = 1'b1;
              state_nxt_s = ST_SEEK;
            end else begin
              state_nxt_s = ST_MEASURE;
              cnt_nxt_s   = cnt_r + CNT_ONE;
              min_nxt_s   = smin(min_r, sample_s);
              max_nxt_s   = smax(max_r, sample_s);
            end
          end else begin
            state_nxt_s = ST_MEASURE;
          end
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          schmitt_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state, Schmitt state and measurement registers
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      schmitt_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
      min_r     <= VAL_ZERO;
      max_r     <= VAL_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      schmitt_r <= schmitt_nxt_s;
      cnt_r     <= cnt_nxt_s;
      min_r     <= min_nxt_s;
      max_r     <= max_nxt_s;
    end
  end

  // Input ready: never backpressures once out of reset
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
    end
  end

  // One-deep result holding buffer
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 64'h0;
    end else if (offer_s && buf_free_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rec_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= m_axis_tvalid;
    end
  end

  // Sticky overrun flag; a new drop wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      overrun <= 1'b0;
    end else if (offer_s && !buf_free_s) begin
      overrun <= 1'b1;
    end else if (clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

  // Sticky timeout flag; a new saturation wins over a coincident clear
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      timeout <= 1'b0;
    end else if (tmo_set_s) begin
      timeout <= 1'b1;
    end else if (clr) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout;
    end
  end

endmodule

// File: tb/tb_waveform_analyzer.sv
// -----------------------------------------------------------------------------
// tb_waveform_analyzer
//
// Directed bench for waveform_analyzer (CNT_WIDTH=8 so that the counter
// saturation case is reachable quickly). A per-cycle vector table covers the
// hysteresis behaviour; hand-written sequences cover square-wave periods,
// validity gaps, backpressure, timeout, enable drop and reset.
// -----------------------------------------------------------------------------
module tb_waveform_analyzer;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        exp_v;
    logic [63:0] exp_d;
  } vec_t;

  localparam logic [63:0] REC_SQ = 64'h03E8_FC18_0000_0014; // max 1000, min -1000, 20
  localparam logic [63:0] REC_H6 = 64'h0046_FFBA_0000_0006; // max 70, min -70, 6
  localparam logic [63:0] REC_HB = 64'h0046_FFC0_0000_0005; // max 70, min -64, 5

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        clr;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tready;
  logic        overrun;
  logic        timeout;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  logic [63:0] rec_q[$];
  int          rec_cyc_q[$];
  vec_t        tbl[$];

  waveform_analyzer #(
    .AXIS_TDATA_WIDTH(16),
    .DAC_WIDTH(14),
    .CNT_WIDTH(8),
    .HYST(64)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .enable(enable),
    .clr(clr),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .overrun(overrun),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshake monitor, sampled mid-cycle before the consuming edge.
  always @(negedge clk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      rec_q.push_back(m_axis_tdata);
      rec_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic step(input logic en, input logic c, input logic v,
                      input logic [15:0] d, input logic rdy);
    enable        = en;
    clr           = c;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Square wave samples [first, first+n): 10 x +1000 then 10 x -1000.
  // With gaps, each sample is followed by an invalid cycle carrying a large
  // value of opposite sign that would corrupt the result if it were used.
  task automatic sq(input int first, input int n, input logic rdy, input logic gaps);
    logic [15:0] val;
    logic [15:0] junk;
    for (int i = first; i < first + n; i++) begin
      val  = (((i / 10) % 2) == 0) ? 16'sd1000 : -16'sd1000;
      junk = (((i / 10) % 2) == 0) ? -16'sd7000 : 16'sd7000;
      step(1'b1, 1'b0, 1'b1, val, rdy);
      if (gaps) begin
        step(1'b1, 1'b0, 1'b0, junk, rdy);
      end
    end
  endtask

  task automatic reinit();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  function automatic void add(input logic v, input logic [15:0] d,
                              input logic ev, input logic [63:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.exp_v = ev; r.exp_d = ed;
    tbl.push_back(r);
  endfunction

  initial begin
    int base;
    logic stable;

    aresetn       = 1'b0;
    enable        = 1'b0;
    clr           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 16'h0;
    m_axis_tready = 1'b0;

    // Hysteresis table: noise, the 6-sample wave, then threshold boundaries.
    add(1'b1,  16'sd50, 1'b0, 64'h0);
    add(1'b1, -16'sd50, 1'b0, 64'h0);
    add(1'b0, 16'sd200, 1'b0, 64'h0);   // invalid, would be a rising event
    add(1'b1,  16'sd63, 1'b0, 64'h0);
    add(1'b1, -16'sd63, 1'b0, 64'h0);
    add(1'b1,  16'sd50, 1'b0, 64'h0);
    add(1'b1, -16'sd50, 1'b0, 64'h0);
    add(1'b1,   16'sd0, 1'b0, 64'h0);
    add(1'b1,  16'sd40, 1'b0, 64'h0);
    add(1'b1,  16'sd70, 1'b0, 64'h0);   // first rising event
    add(1'b1,  16'sd40, 1'b0, 64'h0);
    add(1'b0, 16'h1F00, 1'b0, 64'h0);   // invalid, would raise the max
    add(1'b1,   16'sd0, 1'b0, 64'h0);
    add(1'b1, -16'sd70, 1'b0, 64'h0);
    add(1'b1,   16'sd0, 1'b0, 64'h0);
    add(1'b1,  16'sd40, 1'b0, 64'h0);
    add(1'b1,  16'sd70, 1'b1, REC_H6);
    add(1'b1,  16'sd40, 1'b0, 64'h0);
    add(1'b1,   16'sd0, 1'b0, 64'h0);
    add(1'b1, -16'sd70, 1'b0, 64'h0);
    add(1'b1,   16'sd0, 1'b0, 64'h0);
    add(1'b1,  16'sd40, 1'b0, 64'h0);
    add(1'b1,  16'sd70, 1'b1, REC_H6);
    add(1'b1, -16'sd63, 1'b0, 64'h0);   // above -HYST: stays HIGH
    add(1'b1,  16'sd64, 1'b0, 64'h0);   // already HIGH: no event
    add(1'b1, -16'sd64, 1'b0, 64'h0);   // exactly -HYST: falls
    add(1'b1,  16'sd63, 1'b0, 64'h0);   // below +HYST: no event
    add(1'b1,  16'sd64, 1'b1, REC_HB);  // exactly +HYST: rising event

    // Reset values
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tdata", m_axis_tdata, 64'h0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    aresetn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("s_tready_after_rst", 64'(s_axis_tready), 64'd1);

    // Square wave, every cycle valid
    reinit();
    base = rec_q.size();
    sq(0, 100, 1'b1, 1'b0);
    chk("sq_count", 64'(rec_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (rec_q.size() > base + i) chk("sq_data", rec_q[base + i], REC_SQ);
      if (i > 0 && rec_q.size() > base + i)
        chk("sq_spacing", 64'(rec_cyc_q[base + i] - rec_cyc_q[base + i - 1]), 64'd20);
    end

    // Square wave with validity gaps
    reinit();
    base = rec_q.size();
    sq(0, 100, 1'b1, 1'b1);
    chk("gap_count", 64'(rec_q.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (rec_q.size() > base + i) chk("gap_data", rec_q[base + i], REC_SQ);
      if (i > 0 && rec_q.size() > base + i)
        chk("gap_spacing", 64'(rec_cyc_q[base + i] - rec_cyc_q[base + i - 1]), 64'd40);
    end

    // Hysteresis table
    reinit();
    base = rec_q.size();
    foreach (tbl[k]) begin
      step(1'b1, 1'b0, tbl[k].v, tbl[k].d, 1'b1);
      chk("hyst_valid", 64'(m_axis_tvalid), 64'(tbl[k].exp_v));
      if (tbl[k].exp_v) chk("hyst_data", m_axis_tdata, tbl[k].exp_d);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("hyst_count", 64'(rec_q.size() - base), 64'd3);

    // Backpressure: hold, overrun, clear, single release
    reinit();
    base = rec_q.size();
    sq(0, 21, 1'b0, 1'b0);
    chk("bp_load_valid", 64'(m_axis_tvalid), 64'd1);
    chk("bp_load_data", m_axis_tdata, REC_SQ);
    stable = 1'b1;
    for (int i = 21; i < 50; i++) begin
      sq(i, 1, 1'b0, 1'b0);
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== REC_SQ) stable = 1'b0;
      if (i == 39) chk("bp_no_overrun_yet", 64'(overrun), 64'd0);
      if (i == 40) chk("bp_overrun", 64'(overrun), 64'd1);
    end
    chk("bp_stable", 64'(stable), 64'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("bp_clr_overrun", 64'(overrun), 64'd0);
    chk("bp_still_valid", 64'(m_axis_tvalid), 64'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("bp_one_handshake", 64'(rec_q.size() - base), 64'd1);
    if (rec_q.size() > base) chk("bp_release_data", rec_q[base], REC_SQ);
    chk("bp_drained", 64'(m_axis_tvalid), 64'd0);

    // Timeout at 255 counted samples (CNT_WIDTH=8)
    reinit();
    base = rec_q.size();
    for (int i = 0; i < 254; i++) step(1'b1, 1'b0, 1'b1, 16'sd500, 1'b1);
    chk("tmo_at_254", 64'(timeout), 64'd0);
    step(1'b1, 1'b0, 1'b1, 16'sd500, 1'b1);
    chk("tmo_at_255", 64'(timeout), 64'd1);
    chk("tmo_no_record", 64'(rec_q.size() - base), 64'd0);
    sq(0, 80, 1'b1, 1'b0);
    chk("tmo_recover_count", 64'(rec_q.size() - base), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (rec_q.size() > base + i) chk("tmo_recover_data", rec_q[base + i], REC_SQ);
    end
    chk("tmo_sticky", 64'(timeout), 64'd1);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    chk("tmo_clr", 64'(timeout), 64'd0);

    // Enable drop with a record pending
    reinit();
    sq(0, 30, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'sd1000, 1'b0);
    chk("en_hold_valid", 64'(m_axis_tvalid), 64'd1);
    chk("en_hold_data", m_axis_tdata, REC_SQ);
    base = rec_q.size();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("en_delivered", 64'(rec_q.size() - base), 64'd1);
    if (rec_q.size() > base) chk("en_delivered_data", rec_q[base], REC_SQ);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    base = rec_q.size();
    sq(0, 20, 1'b1, 1'b0);
    chk("en_one_event_no_rec", 64'(rec_q.size() - base), 64'd0);
    sq(20, 2, 1'b1, 1'b0);
    chk("en_two_events_rec", 64'(rec_q.size() - base), 64'd1);
    if (rec_q.size() > base) chk("en_new_data", rec_q[base], REC_SQ);

    // Reset mid-operation with a pending record and overrun set
    reinit();
    sq(0, 41, 1'b0, 1'b0);
    chk("mrst_pre_overrun", 64'(overrun), 64'd1);
    aresetn = 1'b0;
    step(1'b1, 1'b0, 1'b1, 16'sd1000, 1'b0);
    chk("mrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mrst_m_tdata", m_axis_tdata, 64'h0);
    chk("mrst_overrun", 64'(overrun), 64'd0);
    chk("mrst_s_tready", 64'(s_axis_tready), 64'd0);
    aresetn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("mrst_s_tready_back", 64'(s_axis_tready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
